freq_sel_ctrl: RTL and testbench
================================

# freq_sel_ctrl

Sequencer that owns the 4-bit tap select of the 64-step VCO frequency divider and changes it without runt pulses on the divided output. It runs in the Fin (VCO) clock domain. It accepts select-change requests over a req/ack handshake, gates the divider output off, and commits the new select only on a divider-counter boundary where the old and new taps both restart a period. It then re-enables the output after a settle hold.

## Interface
Parameters:
- RST_SEL, 4'd6: select value loaded at reset (the 500 kHz tap).
- HOLD_CYC, 2: Fin cycles the gate stays off after commit; legal range 1..15.

Ports:
- Fin  in  1  VCO clock; all logic on posedge.
- Resetn  in  1  reset; asynchronous, active-low.
- sel_req  in  1  level request. Held high with sel_new stable until sel_ack.
- sel_new  in  4  requested select: 0 = Fin, k = divider bit k-1.
- div_cnt  in  15  live divider counter value, same clock domain.
- Fsel  out  4  registered select driving the 16:1 mux.
- gate_en  out  1  output enable for the mux result; 0 forces Fout low.
- sel_ack  out  1  one-cycle pulse when the requested select is in effect.
- busy  out  1  high whenever state is not IDLE.

## Operation
Boundary rule:
- m = max(Fsel, sel_cap).
- bnd = 1 if m == 0; otherwise bnd = &div_cnt[m-1:0].
- When bnd is 1, the next edge wraps both taps to 0, so both start a new period together.

States:
- IDLE
  - Accept when sel_req=1 and the armed flag is set. Capture sel_new into sel_cap and clear armed.
  - If sel_new == Fsel → ACK (no gating).
  - Otherwise gate_en←0 and go to DRAIN.
  - armed is set again when sel_req is sampled low.
- DRAIN
  - gate_en stays 0.
  - On an edge with bnd=1: Fsel←sel_cap, load hold counter with HOLD_CYC, go to SETTLE.
  - Worst-case wait is 2^15 cycles; there is no timeout.
- SETTLE
  - Hold counter decrements each edge.
  - On the edge where it reaches 0: gate_en←1 and go to ACK.
- ACK
  - sel_ack=1 for exactly one cycle, then IDLE.

Other rules:
- sel_req changes while busy are ignored.
- sel_new is sampled only at acceptance.
- A request still high after ack is not re-accepted until sel_req has been sampled low for at least 1 cycle.
- Reset mid-operation (async): state→IDLE, pending request dropped, no ack issued, armed←1.

## Timing
Reset values:
- Fsel=RST_SEL, gate_en=1, sel_ack=0, busy=0.
- state=IDLE, hold counter=0, armed=1.

Latencies:
- Acceptance at edge t0. gate_en and busy change after t0.
- Same-select request: sel_ack high in cycle t0+1; gate_en never drops.
- Changed select:
  - Fsel updates at the first edge tb > t0 where bnd=1 was sampled.
  - gate_en returns to 1 at edge tb+HOLD_CYC.
  - sel_ack pulses in cycle tb+HOLD_CYC+1.
  - busy falls after the ack cycle.
- bnd is evaluated in the same cycle as state, using the old Fsel and sel_cap. This guarantees the commit edge is the counter wrap of bits [m-1:0].
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package freq_sel_pkg:
  - FSEL_W=4, DIV_W=15.
  - state enum {IDLE, DRAIN, SETTLE, ACK}.
  - HOLD_W=4.
  - function max_sel.
- Sub-module sel_boundary_det (combinational): inputs sel_a, sel_b, div_cnt; output bnd.
  - Implemented as a mask built from max_sel, so it can be unit-tested exhaustively.
- Top freq_sel_ctrl holds the FSM, capture registers, hold counter and armed flag.

## Test plan
- Reset release with the counter free-running → Fsel=6, gate_en=1, busy=0, sel_ack=0; no ack over 100 cycles.
- Fsel=6, request sel_new=3 at div_cnt=10:
  - gate_en→0 on the next edge.
  - Fsel→3 on the edge after div_cnt=63 is sampled.
  - gate_en→1 two edges later; a single sel_ack follows.
- Request 0→1: commit at the first cycle with div_cnt[0]=1; with HOLD_CYC=2 the ack arrives at most 4 cycles after acceptance.
- Request sel_new=6 while Fsel=6 → sel_ack on the next cycle; gate_en stays 1 throughout.
- sel_req held high for 50 cycles after ack → exactly one ack. After dropping for 1 cycle and re-raising with sel_new=9 → a second transaction runs with commit at div_cnt[8:0]=511.
- Resetn pulsed low during DRAIN (request 6→15) → Fsel=6 and gate_en=1 immediately, no ack; a new request after release completes normally.

Source files
------------

// File: rtl/freq_sel_pkg.sv
// Shared widths, FSM state encoding and select helper for the VCO divider
// tap-select sequencer.
package freq_sel_pkg;
   localparam int unsigned FSEL_W = 4;
   localparam int unsigned DIV_W  = 15;
   localparam int unsigned HOLD_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SETTLE,
      ACK
   } state_t;

   function automatic logic [FSEL_W-1:0] max_sel(input logic [FSEL_W-1:0] a,
                                                  input logic [FSEL_W-1:0] b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sel_boundary_det.sv
// Flags the divider-counter cycle after which both the old and new taps
// restart a period together (low max(sel_a, sel_b) counter bits all ones).
module sel_boundary_det
   import freq_sel_pkg::*;
(
   input  logic [FSEL_W-1:0] sel_a,
   input  logic [FSEL_W-1:0] sel_b,
   input  logic [DIV_W-1:0]  div_cnt,
   output logic              bnd
);
   logic [FSEL_W-1:0] m;
   logic [DIV_W-1:0]  mask;

   always_comb begin
      m    = max_sel(sel_a, sel_b);
      // m=0 gives an empty mask (always a boundary); m=15 covers every bit
      mask = ~({DIV_W{1'b1}} << m);
      bnd  = &(div_cnt | ~mask);
   end
endmodule

// File: rtl/freq_sel_ctrl.sv
// Glitch-free tap-select sequencer: gates the divided clock off, commits the
// new select on a shared counter wrap, holds off, then re-enables and acks.
module freq_sel_ctrl
   import freq_sel_pkg::*;
#(
   parameter logic [FSEL_W-1:0] RST_SEL  = 4'd6,
   parameter int unsigned       HOLD_CYC = 2
)(
   input  logic              Fin,
   input  logic              Resetn,
   input  logic              sel_req,
   input  logic [FSEL_W-1:0] sel_new,
   input  logic [DIV_W-1:0]  div_cnt,
   output logic [FSEL_W-1:0] Fsel,
   output logic              gate_en,
   output logic              sel_ack,
   output logic              busy
);
   state_t            state_q;
   logic [FSEL_W-1:0] fsel_q;
   logic [FSEL_W-1:0] cap_q;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;
   logic              gate_q;
   logic              ack_q;
   logic              busy_q;
   logic              armed_q;
   logic              bnd;

   sel_boundary_det u_bnd (
      .sel_a   (fsel_q),
      .sel_b   (cap_q),
      .div_cnt (div_cnt),
      .bnd     (bnd)
   );

   always_comb hold_d = hold_q - HOLD_W'(1);

   always_ff @(posedge Fin or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         fsel_q  <= RST_SEL;
         cap_q   <= RST_SEL;
         hold_q  <= '0;
         gate_q  <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         ack_q <= 1'b0;
         // Re-arm only after the requester has been seen low once
         if (!sel_req) armed_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sel_req && armed_q) begin
                  cap_q   <= sel_new;
                  armed_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (sel_new == fsel_q) begin
                     ack_q   <= 1'b1;
                     state_q <= ACK;
                  end else begin
                     gate_q  <= 1'b0;
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (bnd) begin
                  fsel_q  <= cap_q;
                  hold_q  <= HOLD_W'(HOLD_CYC);
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               hold_q <= hold_d;
               if (hold_d == '0) begin
                  gate_q  <= 1'b1;
                  ack_q   <= 1'b1;
                  state_q <= ACK;
               end
            end
            ACK: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Fsel    = fsel_q;
   assign gate_en = gate_q;
   assign sel_ack = ack_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Directed bench for freq_sel_ctrl with a scoreboard of expected ack cycle
// and committed select per request.
module tb_freq_sel_ctrl;
   localparam int H = 2;

   logic        Fin     = 1'b0;
   logic        Resetn  = 1'b0;
   logic        sel_req = 1'b0;
   logic [3:0]  sel_new = 4'd0;
   logic [14:0] div_cnt = 15'd0;
   logic [3:0]  Fsel;
   logic        gate_en;
   logic        sel_ack;
   logic        busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int fsel_m = 6;

   typedef struct {
      int fsel;
      int k;
   } exp_t;
   exp_t sbq[$];

   freq_sel_ctrl #(.RST_SEL(4'd6), .HOLD_CYC(H)) dut (
      .Fin     (Fin),
      .Resetn  (Resetn),
      .sel_req (sel_req),
      .sel_new (sel_new),
      .div_cnt (div_cnt),
      .Fsel    (Fsel),
      .gate_en (gate_en),
      .sel_ack (sel_ack),
      .busy    (busy)
   );

   always #5 Fin = ~Fin;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; the counter value for the next edge is set after it.
   task automatic step();
      @(posedge Fin);
      #1;
      div_cnt = div_cnt + 15'd1;
   endtask

   task automatic run_req(input int nsel, input int start, input bit keep, output int kobs);
      int          old;
      int          m;
      int          kb;
      int          ka;
      logic [31:0] mask;
      bit          changed;
      bit          got;
      exp_t        e;
      old     = fsel_m;
      changed = (nsel != old);
      kobs    = -1;
      if (changed) begin
         m    = (old > nsel) ? old : nsel;
         mask = (32'd1 << m) - 32'd1;
         kb   = 1;
         while (((start + kb) & mask) != mask) kb++;
         ka = kb + H;
      end else begin
         kb = 0;
         ka = 0;
      end
      sbq.push_back('{nsel, ka});
      div_cnt = 15'(start);
      sel_new = 4'(nsel);
      sel_req = 1'b1;
      got     = 1'b0;
      for (int k = 0; k <= ka + 4 && !got; k++) begin
         step();
         chk("fsel", 32'(Fsel), (k >= kb) ? nsel : old);
         chk("gate_en", 32'(gate_en), (changed && k < ka) ? 0 : 1);
         chk("busy", 32'(busy), 1);
         if (sel_ack === 1'b1) begin
            got  = 1'b1;
            kobs = k;
            chk("sb_size", sbq.size(), 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("ack_cycle", k, e.k);
               chk("ack_fsel", 32'(Fsel), e.fsel);
            end
         end
      end
      chk("ack_seen", 32'(got), 1);
      if (!got && sbq.size() > 0) void'(sbq.pop_front());
      if (!keep) sel_req = 1'b0;
      step();
      chk("ack_low", 32'(sel_ack), 0);
      chk("busy_low", 32'(busy), 0);
      chk("gate_idle", 32'(gate_en), 1);
      fsel_m = nsel;
   endtask

   initial begin
      int acks;
      int kobs;

      // Reset with counter running
      for (int i = 0; i < 3; i++) step();
      Resetn = 1'b1;
      step();
      chk("rst_fsel", 32'(Fsel), 6);
      chk("rst_gate", 32'(gate_en), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(sel_ack), 0);
      acks = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sel_ack === 1'b1) acks++;
      end
      chk("rst_no_ack", acks, 0);

      // 6 -> 3 accepted at div_cnt=10, commit after 63 sampled
      run_req(3, 10, 1'b0, kobs);
      chk("6to3_kobs", kobs, 55);
      // 3 -> 0, then 0 -> 1 (commit on first odd count)
      run_req(0, 100, 1'b0, kobs);
      run_req(1, 4, 1'b0, kobs);
      chk("0to1_le4", 32'(kobs >= 0 && kobs <= 4), 1);
      // back to 6, then same-select request held high afterwards
      run_req(6, 20, 1'b0, kobs);
      run_req(6, 0, 1'b1, kobs);
      chk("same_kobs", kobs, 0);
      acks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (sel_ack === 1'b1) acks++;
         if (busy === 1'b1) acks += 100;
      end
      chk("held_no_reaccept", acks, 0);
      sel_req = 1'b0;
      step();
      run_req(9, 500, 1'b0, kobs);
      chk("6to9_kobs", kobs, 11 + H);

      // Reset restores RST_SEL, then reset again mid-DRAIN of 6 -> 15
      Resetn = 1'b0;
      #2;
      Resetn = 1'b1;
      fsel_m = 6;
      step();
      chk("rst2_fsel", 32'(Fsel), 6);
      div_cnt = 15'd0;
      sel_new = 4'd15;
      sel_req = 1'b1;
      step();
      chk("drain_gate", 32'(gate_en), 0);
      chk("drain_busy", 32'(busy), 1);
      for (int i = 0; i < 4; i++) step();
      chk("drain_fsel", 32'(Fsel), 6);
      Resetn  = 1'b0;
      sel_req = 1'b0;
      #1;
      chk("arst_fsel", 32'(Fsel), 6);
      chk("arst_gate", 32'(gate_en), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ack", 32'(sel_ack), 0);
      #2;
      Resetn = 1'b1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sel_ack === 1'b1) acks++;
      end
      chk("arst_no_ack", acks, 0);
      run_req(2, 30, 1'b0, kobs);
      chk("post_rst_kobs", kobs, 33 + H);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
